red_pitaya_dac_out: RTL and testbench

Output-side counterpart of the ADC capture block. It takes signed two's-complement samples for two channels from the processing fabric in the adc_clk domain and saturates them to DAC width. It converts them to the DAC's inverted-magnitude code, {sign, ~magnitude}, and registers them for the DDR/ODDR output stage. It also sequences the DAC reset, holds the DAC at midscale until enabled and settled, and reports sticky saturation flags.

---
 rtl/red_pitaya_dac_out.sv | 215 +++++++++++++++++++++
 tb/tb_red_pitaya_dac_out.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_dac_out.sv
//------------------------------------------------------------------------------
// red_pitaya_dac_out
//
// Output-side counterpart of the ADC capture block. Signed two's-complement
// samples for two channels are saturated to DAC width and converted to the
// DAC's inverted-magnitude code {sign, ~magnitude}. The codes are registered
// for the DDR/ODDR output stage. The block also sequences the DAC reset, holds
// the DAC at midscale until it is enabled and settled, and keeps sticky
// saturation flags.
//
// Ports:
//   adc_clk      in   sole clock (125 MHz)
//   adc_rst      in   asynchronous, active-high reset
//   enable       in   level-sensitive request for live output
//   dat_a_i      in   channel A sample, signed, IN_DATA_WIDTH
//   dat_b_i      in   channel B sample, signed, IN_DATA_WIDTH
//   dat_valid_i  in   qualifies dat_a_i / dat_b_i this cycle
//   sat_clr_i    in   clears the sticky saturation flags
//   dac_dat_a_o  out  channel A DAC code, registered
//   dac_dat_b_o  out  channel B DAC code, registered
//   dac_rst_o    out  DAC reset, active-high
//   dac_active_o out  high while output is live (RUN)
//   sat_a_o      out  sticky: a channel A sample was clipped
//   sat_b_o      out  sticky: a channel B sample was clipped
//------------------------------------------------------------------------------
module red_pitaya_dac_out #(
    parameter int DAC_DATA_WIDTH = 14,
    parameter int IN_DATA_WIDTH  = 16,
    parameter int RST_CYCLES     = 16,
    parameter int SETTLE_CYCLES  = 64
) (
    input  logic                             adc_clk,
    input  logic                             adc_rst,
    input  logic                             enable,
    input  logic signed [IN_DATA_WIDTH-1:0]  dat_a_i,
    input  logic signed [IN_DATA_WIDTH-1:0]  dat_b_i,
    input  logic                             dat_valid_i,
    input  logic                             sat_clr_i,
    output logic        [DAC_DATA_WIDTH-1:0] dac_dat_a_o,
    output logic        [DAC_DATA_WIDTH-1:0] dac_dat_b_o,
    output logic                             dac_rst_o,
    output logic                             dac_active_o,
    output logic                             sat_a_o,
    output logic                             sat_b_o
);

    localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    // Code for signed zero: sign 0, inverted magnitude all ones.
    localparam logic [DAC_DATA_WIDTH-1:0] MID = {1'b0, {(DAC_DATA_WIDTH-1){1'b1}}};

    // Representable DAC range, expressed at input width for comparison.
    localparam logic signed [IN_DATA_WIDTH-1:0] IN_MAX =
        IN_DATA_WIDTH'((2 ** (DAC_DATA_WIDTH-1)) - 1);
    localparam logic signed [IN_DATA_WIDTH-1:0] IN_MIN =
        IN_DATA_WIDTH'(-(2 ** (DAC_DATA_WIDTH-1)));

    typedef enum logic [1:0] {
        ST_RST,
        ST_MUTE,
        ST_RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic signed [DAC_DATA_WIDTH-1:0] s_a_p1;
    logic signed [DAC_DATA_WIDTH-1:0] s_b_p1;
    logic        [DAC_DATA_WIDTH-1:0] code_a_p2;
    logic        [DAC_DATA_WIDTH-1:0] code_b_p2;

    logic run;
    logic clip_a;
    logic clip_b;

    //--------------------------------------------------------------------------
    // Saturation / code helpers
    //--------------------------------------------------------------------------
    function automatic logic is_clipped(input logic signed [IN_DATA_WIDTH-1:0] x);
        return (x > IN_MAX) || (x < IN_MIN);
    endfunction

    function automatic logic signed [DAC_DATA_WIDTH-1:0] saturate(
        input logic signed [IN_DATA_WIDTH-1:0] x
    );
        logic signed [DAC_DATA_WIDTH-1:0] r;
        if (x > IN_MAX)
            r = IN_MAX[DAC_DATA_WIDTH-1:0];
        else if (x < IN_MIN)
            r = IN_MIN[DAC_DATA_WIDTH-1:0];
        else
            r = x[DAC_DATA_WIDTH-1:0];
        return r;
    endfunction

    // The DAC wants sign followed by the bitwise-inverted lower bits, so
    // full positive scale maps to 0 and full negative scale to all ones.
    function automatic logic [DAC_DATA_WIDTH-1:0] dac_code(
        input logic signed [DAC_DATA_WIDTH-1:0] s
    );
        return {s[DAC_DATA_WIDTH-1], ~s[DAC_DATA_WIDTH-2:0]};
    endfunction

    assign run    = (state == ST_RUN);
    assign clip_a = is_clipped(dat_a_i);
    assign clip_b = is_clipped(dat_b_i);

    //--------------------------------------------------------------------------
    // Control: reset sequencing, settle timer, RUN indication
    //--------------------------------------------------------------------------
    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            state        <= ST_RST;
            cnt          <= '0;
            dac_rst_o    <= 1'b1;
            dac_active_o <= 1'b0;
        end else begin
            case (state)
                ST_RST: begin
                    if (cnt == RST_LAST) begin
                        state     <= ST_MUTE;
                        cnt       <= '0;
                        dac_rst_o <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_MUTE: begin
                    // Any low cycle on enable restarts the settle window.
                    if (!enable) begin
                        cnt <= '0;
                    end else if (cnt == SETTLE_LAST) begin
                        state        <= ST_RUN;
                        cnt          <= '0;
                        dac_active_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state        <= ST_MUTE;
                        cnt          <= '0;
                        dac_active_o <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_RST;
                    cnt          <= '0;
                    dac_rst_o    <= 1'b1;
                    dac_active_o <= 1'b0;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Stage p1: saturated sample, forced to zero outside RUN so the first
    // live output is midscale until a valid sample arrives
    //--------------------------------------------------------------------------
    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            s_a_p1 <= '0;
            s_b_p1 <= '0;
        end else if (!run) begin
            s_a_p1 <= '0;
            s_b_p1 <= '0;
        end else if (dat_valid_i) begin
            s_a_p1 <= saturate(dat_a_i);
            s_b_p1 <= saturate(dat_b_i);
        end
    end

    //--------------------------------------------------------------------------
    // Stage p2: DAC code register feeding the ODDR stage
    //--------------------------------------------------------------------------
    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            code_a_p2 <= MID;
            code_b_p2 <= MID;
        end else if (run) begin
            code_a_p2 <= dac_code(s_a_p1);
            code_b_p2 <= dac_code(s_b_p1);
        end else begin
            code_a_p2 <= MID;
            code_b_p2 <= MID;
        end
    end

    assign dac_dat_a_o = code_a_p2;
    assign dac_dat_b_o = code_b_p2;

    // Sticky clip flags; a clip in the same cycle as a clear still sets the flag.
    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            sat_a_o <= 1'b0;
            sat_b_o <= 1'b0;
        end else begin
            if (run && dat_valid_i && clip_a)
                sat_a_o <= 1'b1;
            else if (sat_clr_i)
                sat_a_o <= 1'b0;

            if (run && dat_valid_i && clip_b)
                sat_b_o <= 1'b1;
            else if (sat_clr_i)
                sat_b_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_red_pitaya_dac_out.sv
module tb_red_pitaya_dac_out;

    logic               adc_clk;
    logic               adc_rst;
    logic               enable;
    logic signed [15:0] dat_a_i;
    logic signed [15:0] dat_b_i;
    logic               dat_valid_i;
    logic               sat_clr_i;
    logic [13:0]        dac_dat_a_o;
    logic [13:0]        dac_dat_b_o;
    logic               dac_rst_o;
    logic               dac_active_o;
    logic               sat_a_o;
    logic               sat_b_o;

    int errors = 0;
    int checks = 0;

    red_pitaya_dac_out #(
        .DAC_DATA_WIDTH (14),
        .IN_DATA_WIDTH  (16),
        .RST_CYCLES     (16),
        .SETTLE_CYCLES  (64)
    ) dut (
        .adc_clk      (adc_clk),
        .adc_rst      (adc_rst),
        .enable       (enable),
        .dat_a_i      (dat_a_i),
        .dat_b_i      (dat_b_i),
        .dat_valid_i  (dat_valid_i),
        .sat_clr_i    (sat_clr_i),
        .dac_dat_a_o  (dac_dat_a_o),
        .dac_dat_b_o  (dac_dat_b_o),
        .dac_rst_o    (dac_rst_o),
        .dac_active_o (dac_active_o),
        .sat_a_o      (sat_a_o),
        .sat_b_o      (sat_b_o)
    );

    initial adc_clk = 1'b0;
    always #4 adc_clk = ~adc_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge adc_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic signed [15:0] va [6];
    logic [31:0]        ea [6];

    initial begin
        va = '{16'sd0, 16'sd8191, -16'sd1, -16'sd8192, 16'sd20000, -16'sd20000};
        ea = '{32'h1FFF, 32'h0000, 32'h2000, 32'h3FFF, 32'h0000, 32'h3FFF};

        adc_rst     = 1'b1;
        enable      = 1'b1;
        dat_a_i     = '0;
        dat_b_i     = '0;
        dat_valid_i = 1'b0;
        sat_clr_i   = 1'b0;

        // 1. reset state and reset sequence
        tick(3);
        check("rst_dat_a",  32'(dac_dat_a_o),  32'h1FFF);
        check("rst_dat_b",  32'(dac_dat_b_o),  32'h1FFF);
        check("rst_dac_rst", 32'(dac_rst_o),   32'd1);
        check("rst_active", 32'(dac_active_o), 32'd0);
        check("rst_sat_a",  32'(sat_a_o),      32'd0);
        check("rst_sat_b",  32'(sat_b_o),      32'd0);
        adc_rst = 1'b0;

        for (int i = 1; i <= 16; i++) begin
            tick(1);
            check("seq_dac_rst", 32'(dac_rst_o), (i < 16) ? 32'd1 : 32'd0);
        end
        for (int i = 1; i <= 64; i++) begin
            tick(1);
            check("seq_active", 32'(dac_active_o), (i == 64) ? 32'd1 : 32'd0);
            check("seq_dat_a",  32'(dac_dat_a_o),  32'h1FFF);
        end

        // 2. conversion, latency, saturation flag
        for (int k = 1; k <= 7; k++) begin
            if (k <= 6) begin
                dat_a_i     = va[k-1];
                dat_valid_i = 1'b1;
            end else begin
                dat_valid_i = 1'b0;
            end
            tick(1);
            if (k >= 2) check("conv_a", 32'(dac_dat_a_o), ea[k-2]);
            check("conv_sat_a", 32'(sat_a_o), (k >= 5) ? 32'd1 : 32'd0);
            check("conv_sat_b", 32'(sat_b_o), 32'd0);
        end
        check("conv_b_zero", 32'(dac_dat_b_o), 32'h1FFF);

        // 3. hold without valid
        dat_a_i     = 16'sd100;
        dat_valid_i = 1'b1;
        tick(1);
        dat_valid_i = 1'b0;
        dat_a_i     = -16'sd3000;
        tick(1);
        check("hold_first", 32'(dac_dat_a_o), 32'h1F9B);
        for (int i = 0; i < 10; i++) begin
            dat_a_i = 16'(i * 1234 - 7000);
            dat_b_i = 16'(i * 4321);
            tick(1);
            check("hold_a", 32'(dac_dat_a_o), 32'h1F9B);
        end
        dat_b_i = '0;

        // 4. enable drop and settle restart
        enable = 1'b0;
        tick(1);
        check("drop_active", 32'(dac_active_o), 32'd0);
        tick(1);
        check("drop_mid_a", 32'(dac_dat_a_o), 32'h1FFF);
        check("drop_mid_b", 32'(dac_dat_b_o), 32'h1FFF);
        enable = 1'b1;
        tick(30);
        check("partial_active", 32'(dac_active_o), 32'd0);
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            tick(1);
            check("resettle_active", 32'(dac_active_o), (i == 64) ? 32'd1 : 32'd0);
        end
        check("resettle_mid", 32'(dac_dat_a_o), 32'h1FFF);

        // 5. flag clear race and independence
        sat_clr_i = 1'b1;
        tick(1);
        check("clr_sat_a", 32'(sat_a_o), 32'd0);
        dat_a_i     = 16'sd20000;
        dat_b_i     = -16'sd20000;
        dat_valid_i = 1'b1;
        tick(1);
        check("race_sat_a", 32'(sat_a_o), 32'd1);
        check("race_sat_b", 32'(sat_b_o), 32'd1);
        dat_a_i = 16'sd5;
        dat_b_i = 16'sd5;
        tick(1);
        check("clr2_sat_a", 32'(sat_a_o), 32'd0);
        check("clr2_sat_b", 32'(sat_b_o), 32'd0);
        sat_clr_i   = 1'b0;
        dat_a_i     = 16'sd20000;
        dat_b_i     = 16'sd7;
        tick(1);
        check("indep_sat_a", 32'(sat_a_o), 32'd1);
        check("indep_sat_b", 32'(sat_b_o), 32'd0);
        sat_clr_i   = 1'b1;
        dat_valid_i = 1'b0;
        tick(1);
        sat_clr_i = 1'b0;
        enable    = 1'b0;
        tick(1);
        dat_a_i     = 16'sd20000;
        dat_valid_i = 1'b1;
        tick(1);
        check("mute_no_sat_a", 32'(sat_a_o), 32'd0);
        dat_valid_i = 1'b0;
        enable      = 1'b1;
        tick(64);
        check("rerun_active", 32'(dac_active_o), 32'd1);

        // 6. asynchronous reset mid-RUN
        dat_a_i     = 16'sd100;
        dat_b_i     = 16'sd20000;
        dat_valid_i = 1'b1;
        tick(1);
        dat_valid_i = 1'b0;
        tick(1);
        check("pre_rst_a",     32'(dac_dat_a_o), 32'h1F9B);
        check("pre_rst_b",     32'(dac_dat_b_o), 32'h0000);
        check("pre_rst_sat_b", 32'(sat_b_o),     32'd1);
        #2;
        adc_rst = 1'b1;
        #1;
        check("arst_dat_a",  32'(dac_dat_a_o),  32'h1FFF);
        check("arst_dat_b",  32'(dac_dat_b_o),  32'h1FFF);
        check("arst_dac_rst", 32'(dac_rst_o),   32'd1);
        check("arst_active", 32'(dac_active_o), 32'd0);
        check("arst_sat_a",  32'(sat_a_o),      32'd0);
        check("arst_sat_b",  32'(sat_b_o),      32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
